uart_rx_fifo: RTL and testbench

Byte buffer between the UART receiver and the receive-side command interface. Each received byte, marked by the receiver's one-cycle done tick, is stored in a circular queue. The consumer pops bytes at its own pace, so back-to-back frames are not lost while the ALU/transmit path is busy. Output data is first-word-fall-through: the head byte is always visible on `r_data` while the queue is non-empty.

---
 rtl/uart_pkg.sv | 9 +
 rtl/fifo_ctrl.sv | 75 +++++++
 rtl/uart_rx_fifo.sv | 62 ++++++
 tb/tb_uart_rx_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared defaults for the UART receive path.
// Frame payload width and receive FIFO geometry.
package uart_pkg;

    localparam int uart_size      = 8;
    localparam int fifo_addr_bits = 4;
    localparam int fifo_afull_lvl = 12;

endpackage

// File: rtl/fifo_ctrl.sv
// Receive FIFO control: pointers, occupancy, status flags.
// Sticky error flags survive until reset or clr_err.
module fifo_ctrl
    import uart_pkg::*;
#(
    parameter int addr_bits = fifo_addr_bits,
    parameter int afull_lvl = fifo_afull_lvl
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 rd,
    input  logic                 clr_err,
    output logic [addr_bits-1:0] wp,
    output logic [addr_bits-1:0] rp,
    output logic                 we,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic [addr_bits:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [addr_bits:0] depth_c = (addr_bits + 1)'(1 << addr_bits);
    localparam logic [addr_bits:0] afull_c = (addr_bits + 1)'(afull_lvl);

    logic               do_rd;
    logic               do_wr;
    logic [addr_bits:0] count_d;
    logic               ovf_d;
    logic               udf_d;

    // Flags come from the registered count, never from pointers.
    always_comb begin
        empty       = (count == '0);
        full        = (count == depth_c);
        almost_full = (count >= afull_c);
    end

    // Accept logic, next occupancy and sticky-flag next state.
    always_comb begin
        do_rd   = rd & ~empty;
        do_wr   = wr & (~full | do_rd);
        we      = do_wr;
        count_d = count;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count + (addr_bits + 1)'(1);
            2'b01:   count_d = count - (addr_bits + 1)'(1);
            default: count_d = count;
        endcase
        ovf_d = clr_err ? 1'b0 : overflow;
        udf_d = clr_err ? 1'b0 : underflow;
        if (wr && !do_wr) ovf_d = 1'b1;
        if (rd && empty)  udf_d = 1'b1;
    end

    // Pointer, count and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) wp <= wp + addr_bits'(1);
            if (do_rd) rp <= rp + addr_bits'(1);
            count     <= count_d;
            overflow  <= ovf_d;
            underflow <= udf_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte queue between UART receiver and command path.
// First-word-fall-through: head byte shown while non-empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int size      = uart_size,
    parameter int addr_bits = fifo_addr_bits,
    parameter int afull_lvl = fifo_afull_lvl
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic [size-1:0]    w_data,
    input  logic               rd,
    input  logic               clr_err,
    output logic [size-1:0]    r_data,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic [addr_bits:0] count,
    output logic               overflow,
    output logic               underflow
);

    localparam int depth = 1 << addr_bits;

    logic [size-1:0]      mem [depth];
    logic [addr_bits-1:0] wp;
    logic [addr_bits-1:0] rp;
    logic                 we;

    fifo_ctrl #(
        .addr_bits (addr_bits),
        .afull_lvl (afull_lvl)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .rd          (rd),
        .clr_err     (clr_err),
        .wp          (wp),
        .rp          (rp),
        .we          (we),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Storage array; contents are left as-is on reset.
    always_ff @(posedge clk) begin
        if (we) mem[wp] <= w_data;
    end

    // Head byte, forced to zero when the queue is empty.
    always_comb begin
        r_data = empty ? '0 : mem[rp];
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (depth 16, afull 12).
// Inputs change 1ns after the rising edge; outputs checked there too.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_assert = 0;
    int n_fail   = 0;

    uart_rx_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .clr_err     (clr_err),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int d;
        #1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        check("rst_rdata", int'(r_data), 0);
        check("rst_full", int'(full), 0);
        check("rst_afull", int'(almost_full), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_udf", int'(underflow), 0);

        // three writes then three pops
        wr = 1'b1; w_data = 8'h41; step();
        check("w1_rdata", int'(r_data), 'h41);
        check("w1_count", int'(count), 1);
        check("w1_empty", int'(empty), 0);
        w_data = 8'h2B; step();
        w_data = 8'h07; step();
        wr = 1'b0;
        check("w3_count", int'(count), 3);
        check("w3_head", int'(r_data), 'h41);
        rd = 1'b1; step();
        check("p1_rdata", int'(r_data), 'h2B);
        check("p1_count", int'(count), 2);
        step();
        check("p2_rdata", int'(r_data), 'h07);
        check("p2_count", int'(count), 1);
        step();
        check("p3_rdata", int'(r_data), 0);
        check("p3_count", int'(count), 0);
        check("p3_empty", int'(empty), 1);
        rd = 1'b0;

        // fill to depth, one dropped write
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; w_data = 8'(i); step();
            check("fill_count", int'(count), i + 1);
            check("fill_afull", int'(almost_full), (i + 1 >= 12) ? 1 : 0);
            check("fill_full", int'(full), (i == 15) ? 1 : 0);
        end
        w_data = 8'hFF; step();
        wr = 1'b0;
        check("ovf_set", int'(overflow), 1);
        check("ovf_count", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", int'(r_data), i);
            rd = 1'b1; step();
        end
        rd = 1'b0;
        check("drain_empty", int'(empty), 1);
        check("ovf_sticky", int'(overflow), 1);
        clr_err = 1'b1; step();
        clr_err = 1'b0;
        check("ovf_clr", int'(overflow), 0);

        // full with simultaneous write and pop
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; w_data = 8'(8'h10 + i); step();
        end
        w_data = 8'hAA; rd = 1'b1; step();
        wr = 1'b0; rd = 1'b0;
        check("both_full_count", int'(count), 16);
        check("both_full_full", int'(full), 1);
        check("both_full_ovf", int'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            check("both_drain", int'(r_data), (i < 15) ? (8'h11 + i) : 'hAA);
            rd = 1'b1; step();
        end
        rd = 1'b0;
        check("both_drain_cnt", int'(count), 0);

        // empty with simultaneous write and pop
        wr = 1'b1; w_data = 8'h55; rd = 1'b1; step();
        wr = 1'b0; rd = 1'b0;
        check("both_emp_count", int'(count), 1);
        check("both_emp_rdata", int'(r_data), 'h55);
        check("both_emp_udf", int'(underflow), 1);
        clr_err = 1'b1; step();
        clr_err = 1'b0;
        check("udf_clr", int'(underflow), 0);
        check("udf_clr_count", int'(count), 1);
        rd = 1'b1; step();
        check("pop_last", int'(count), 0);
        // pop on empty plus clr_err: the error wins
        clr_err = 1'b1; step();
        rd = 1'b0; clr_err = 1'b0;
        check("udf_wins", int'(underflow), 1);
        check("udf_nochg", int'(count), 0);
        clr_err = 1'b1; step();
        clr_err = 1'b0;

        // pointer wrap
        d = 0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 10; i++) begin
                wr = 1'b1; w_data = 8'(d + i); step();
            end
            wr = 1'b0;
            check("wrap_count", int'(count), 10);
            for (int i = 0; i < 10; i++) begin
                check("wrap_data", int'(r_data), (d + i) & 'hFF);
                rd = 1'b1; step();
            end
            rd = 1'b0;
            d += 10;
        end
        check("wrap_empty", int'(empty), 1);

        // reset mid-operation
        for (int i = 0; i < 7; i++) begin
            wr = 1'b1; w_data = 8'(8'hC0 + i); step();
        end
        wr = 1'b0;
        check("pre_rst_count", int'(count), 7);
        reset = 1'b1; step();
        reset = 1'b0;
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_rdata", int'(r_data), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
